if_id_queue: RTL and testbench

Instruction queue between the AXI instruction-fetch stage and the decode stage of the MIPS core. It buffers fetched instruction words together with their PC and fetch-exception flag. Entries are presented in order to decode with a valid/ready handshake. Decode-side consumers, including the debug instruction-name decoder, see `d_instr` = 0 (NOP) whenever the queue is empty.

---
 rtl/if_id_queue.sv | 104 ++++++++++
 tb/tb_if_id_queue.sv | 177 +++++++++++++++++
 2 files changed

// File: rtl/if_id_queue.sv
// Purpose: in-order instruction queue between instruction fetch and decode, holding {pc, instr, adel}.
// Latency: an entry pushed at edge N is visible on d_* after that edge; there is no f_* to d_* bypass.
// Backpressure: f_ready depends only on stored occupancy; a pop while full frees the slot for the next cycle.
module if_id_queue #(
    parameter int DEPTH = 4,
    parameter int AW    = 2
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          flush,
    input  logic          f_valid,
    input  logic [31:0]   f_pc,
    input  logic [31:0]   f_instr,
    input  logic          f_adel,
    output logic          f_ready,
    output logic          d_valid,
    output logic [31:0]   d_pc,
    output logic [31:0]   d_instr,
    output logic          d_adel,
    input  logic          d_ready,
    output logic [AW:0]   count
);

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] instr;
        logic        adel;
    } entry_t;

    localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);

    // Entry storage is never cleared; only the pointers and the count define what is live.
    entry_t        mem_q [DEPTH];
    logic [AW-1:0] wr_ptr_q, wr_ptr_d;
    logic [AW-1:0] rd_ptr_q, rd_ptr_d;
    logic [AW:0]   count_q, count_d;
    logic          push, pop;
    entry_t        head;

    assign f_ready = (count_q != FULL_CNT);
    assign d_valid = (count_q != '0);
    assign count   = count_q;

    // Flush suppresses both handshakes so a dropped push is never written and a pop is not consumed.
    assign push = f_valid & f_ready & ~flush;
    assign pop  = d_valid & d_ready & ~flush;

    // Next-state for the pointers and occupancy; flush clears everything.
    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (flush) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
        end else begin
            if (push) begin
                wr_ptr_d = wr_ptr_q + AW'(1);
            end
            if (pop) begin
                rd_ptr_d = rd_ptr_q + AW'(1);
            end
            if (push && !pop) begin
                count_d = count_q + (AW+1)'(1);
            end else if (pop && !push) begin
                count_d = count_q - (AW+1)'(1);
            end
        end
    end

    // Pointer and occupancy registers with synchronous reset taking priority over flush.
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // Entry write at the tail; reset blocks the write so a reset cycle has no side effects.
    always_ff @(posedge clk) begin
        if (push && !rst) begin
            mem_q[wr_ptr_q] <= '{pc: f_pc, instr: f_instr, adel: f_adel};
        end
    end

    // Head read; an empty queue presents an all-zero entry so decode sees a NOP.
    always_comb begin
        head = '0;
        if (d_valid) begin
            head = mem_q[rd_ptr_q];
        end
    end

    assign d_pc    = head.pc;
    assign d_instr = head.instr;
    assign d_adel  = head.adel;

endmodule

// File: tb/tb_if_id_queue.sv
// Bench for if_id_queue: directed scenarios followed by randomized traffic.
// Outputs are compared every cycle against a queue-based model of the FIFO rules.
// Inputs change one time unit after the rising edge and are sampled one unit after the edge.
module tb_if_id_queue;

    localparam int DEPTH = 4;
    localparam int AW    = 2;

    logic          clk = 1'b0;
    logic          rst, flush, f_valid, f_adel, f_ready;
    logic [31:0]   f_pc, f_instr;
    logic          d_valid, d_adel, d_ready;
    logic [31:0]   d_pc, d_instr;
    logic [AW:0]   count;

    typedef struct {
        logic [31:0] pc;
        logic [31:0] instr;
        logic        adel;
    } ent_t;

    ent_t mq[$];
    int   checks   = 0;
    int   errors   = 0;
    bit   model_ok = 1'b0;

    if_id_queue #(.DEPTH(DEPTH), .AW(AW)) dut (
        .clk     (clk),
        .rst     (rst),
        .flush   (flush),
        .f_valid (f_valid),
        .f_pc    (f_pc),
        .f_instr (f_instr),
        .f_adel  (f_adel),
        .f_ready (f_ready),
        .d_valid (d_valid),
        .d_pc    (d_pc),
        .d_instr (d_instr),
        .d_adel  (d_adel),
        .d_ready (d_ready),
        .count   (count)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic check_model();
        ent_t e;
        e = '{pc: 32'h0, instr: 32'h0, adel: 1'b0};
        if (mq.size() != 0) e = mq[0];
        chk("m_count",   {29'b0, count},   32'(mq.size()));
        chk("m_d_valid", {31'b0, d_valid}, {31'b0, mq.size() != 0});
        chk("m_f_ready", {31'b0, f_ready}, {31'b0, mq.size() != DEPTH});
        chk("m_d_pc",    d_pc,             e.pc);
        chk("m_d_instr", d_instr,          e.instr);
        chk("m_d_adel",  {31'b0, d_adel},  {31'b0, e.adel});
    endtask

    // One clock cycle: drive inputs, check f_ready before the edge, advance model, check after the edge.
    task automatic cyc(input logic r, input logic fl, input logic fv, input logic [31:0] pc,
                       input logic [31:0] ins, input logic ad, input logic dr);
        bit do_push, do_pop;
        rst = r; flush = fl; f_valid = fv; f_pc = pc; f_instr = ins; f_adel = ad; d_ready = dr;
        #1;
        if (model_ok && !r) chk("pre_f_ready", {31'b0, f_ready}, {31'b0, mq.size() != DEPTH});
        do_push = fv && (mq.size() != DEPTH) && !fl;
        do_pop  = dr && (mq.size() != 0) && !fl;
        @(posedge clk);
        if (r) begin
            mq.delete();
            model_ok = 1'b1;
        end else if (fl) begin
            mq.delete();
        end else begin
            if (do_pop) void'(mq.pop_front());
            if (do_push) mq.push_back('{pc: pc, instr: ins, adel: ad});
        end
        #1;
        if (model_ok) check_model();
    endtask

    task automatic idle(input logic dr);
        cyc(1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 1'b0, dr);
    endtask

    initial begin
        // Reset for two cycles, then idle.
        cyc(1'b1, 1'b0, 1'b0, 32'h0, 32'h0, 1'b0, 1'b0);
        cyc(1'b1, 1'b0, 1'b0, 32'h0, 32'h0, 1'b0, 1'b0);
        idle(1'b0);
        chk("rst_d_valid", {31'b0, d_valid}, 32'd0);
        chk("rst_d_instr", d_instr, 32'h0);
        chk("rst_f_ready", {31'b0, f_ready}, 32'd1);
        chk("rst_count", {29'b0, count}, 32'd0);

        // Fill to full with decode stalled.
        for (int i = 0; i < 4; i++)
            cyc(1'b0, 1'b0, 1'b1, 32'hBFC00000 + 32'(4 * i), 32'h24020001 + 32'(i), 1'b0, 1'b0);
        chk("full_count", {29'b0, count}, 32'd4);
        chk("full_f_ready", {31'b0, f_ready}, 32'd0);
        chk("full_d_pc", d_pc, 32'hBFC00000);
        chk("full_d_instr", d_instr, 32'h24020001);
        cyc(1'b0, 1'b0, 1'b1, 32'hDEAD0000, 32'hDEADBEEF, 1'b0, 1'b0);
        chk("fifth_rejected", {29'b0, count}, 32'd4);

        // Drain from full; the offer in the first drain cycle is refused, the second is taken.
        cyc(1'b0, 1'b0, 1'b1, 32'hBFC00010, 32'h0, 1'b0, 1'b1);
        chk("drain1_instr", d_instr, 32'h24020002);
        cyc(1'b0, 1'b0, 1'b1, 32'hBFC00010, 32'h0, 1'b0, 1'b1);
        chk("drain2_instr", d_instr, 32'h24020003);
        idle(1'b1);
        chk("drain3_instr", d_instr, 32'h24020004);
        idle(1'b1);
        chk("wrap_d_pc", d_pc, 32'hBFC00010);
        chk("wrap_d_instr", d_instr, 32'h0);
        chk("wrap_count", {29'b0, count}, 32'd1);
        idle(1'b1);
        chk("drained_valid", {31'b0, d_valid}, 32'd0);

        // Simultaneous push and pop at count 2.
        cyc(1'b0, 1'b0, 1'b1, 32'h00001000, 32'hA0000001, 1'b0, 1'b0);
        cyc(1'b0, 1'b0, 1'b1, 32'h00001004, 32'hA0000002, 1'b0, 1'b0);
        for (int i = 0; i < 3; i++)
            cyc(1'b0, 1'b0, 1'b1, 32'h00001008 + 32'(4 * i), 32'hA0000003 + 32'(i), 1'b0, 1'b1);
        chk("pp_count", {29'b0, count}, 32'd2);
        chk("pp_head", d_instr, 32'hA0000004);

        // Flush at count 3 with a simultaneous push and pop.
        cyc(1'b0, 1'b0, 1'b1, 32'h00001014, 32'hA0000006, 1'b0, 1'b0);
        chk("pre_flush_count", {29'b0, count}, 32'd3);
        cyc(1'b0, 1'b1, 1'b1, 32'h00002000, 32'hBAD00001, 1'b0, 1'b1);
        chk("flush_count", {29'b0, count}, 32'd0);
        chk("flush_d_valid", {31'b0, d_valid}, 32'd0);
        chk("flush_d_instr", d_instr, 32'h0);
        chk("flush_f_ready", {31'b0, f_ready}, 32'd1);
        cyc(1'b0, 1'b0, 1'b1, 32'h00003000, 32'hC0000001, 1'b0, 1'b0);
        chk("post_flush_head", d_instr, 32'hC0000001);
        cyc(1'b0, 1'b1, 1'b0, 32'h0, 32'h0, 1'b0, 1'b0);

        // Fetch address error flag, then reset with live entries.
        cyc(1'b0, 1'b0, 1'b1, 32'h00000001, 32'h0, 1'b1, 1'b0);
        chk("adel_flag", {31'b0, d_adel}, 32'd1);
        chk("adel_pc", d_pc, 32'h00000001);
        cyc(1'b0, 1'b0, 1'b1, 32'h00000005, 32'h11111111, 1'b0, 1'b0);
        chk("pre_rst_count", {29'b0, count}, 32'd2);
        cyc(1'b1, 1'b0, 1'b1, 32'h00000009, 32'h22222222, 1'b1, 1'b1);
        chk("mid_rst_count", {29'b0, count}, 32'd0);
        chk("mid_rst_adel", {31'b0, d_adel}, 32'd0);
        chk("mid_rst_valid", {31'b0, d_valid}, 32'd0);

        // Randomized traffic; phases alternate between fill-heavy and drain-heavy.
        for (int i = 0; i < 600; i++) begin
            logic r, fl, fv, dr;
            r  = ($urandom_range(0, 79) == 0);
            fl = ($urandom_range(0, 29) == 0);
            if (((i / 40) % 2) == 0) begin
                fv = ($urandom_range(0, 3) != 0);
                dr = ($urandom_range(0, 3) == 0);
            end else begin
                fv = ($urandom_range(0, 3) == 0);
                dr = ($urandom_range(0, 3) != 0);
            end
            cyc(r, fl, fv, $urandom, $urandom, 1'($urandom_range(0, 1)), dr);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
